// File: rtl/scsi_byte_packer_if.sv
// Handshake bundle between the byte packer, its sequencer, the SCSI byte stage and the FIFO.
// The master drives controls, the SCSI byte and FIFO status; the slave (the packer) drives the rest.
interface scsi_byte_packer_if #(parameter int CNT_W = 24);
   logic             START;
   logic             DIR;
   logic             BYTE_STB;
   logic [7:0]       BYTE_IN;
   logic             FLUSH;
   logic             FIFO_FULL;
   logic             FIFO_EMPTY;
   logic             FIFO_WR;
   logic [31:0]      FIFO_ID;
   logic [3:0]       FIFO_BE;
   logic             FIFO_RD;
   logic             BO1;
   logic             BO0;
   logic             BYTE_RDY;
   logic             BUSY;
   logic [CNT_W-1:0] BYTE_CNT;

   modport master (
      output START, DIR, BYTE_STB, BYTE_IN, FLUSH, FIFO_FULL, FIFO_EMPTY,
      input  FIFO_WR, FIFO_ID, FIFO_BE, FIFO_RD, BO1, BO0, BYTE_RDY, BUSY, BYTE_CNT
   );

   modport slave (
      input  START, DIR, BYTE_STB, BYTE_IN, FLUSH, FIFO_FULL, FIFO_EMPTY,
      output FIFO_WR, FIFO_ID, FIFO_BE, FIFO_RD, BO1, BO0, BYTE_RDY, BUSY, BYTE_CNT
   );
endinterface

// File: rtl/scsi_byte_packer.sv
// Byte-lane sequencer between the 32-bit FIFO and the 8-bit SCSI stage: packs SCSI bytes
// into big-endian longwords (S2F) or walks the byte offset across a FIFO longword (F2S).
module scsi_byte_packer #(
   parameter int CNT_W = 24
) (
   input logic               CLK,
   input logic               _RST,
   scsi_byte_packer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      S2F_FILL,
      S2F_WR,
      F2S_WAIT,
      F2S_SEND,
      FLUSH_WR
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d, ptr_n, ptr_inc;
   logic [31:0]      pack_q, pack_d;
   logic [31:0]      id_q, id_d;
   logic [3:0]       be_q, be_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_q, wr_d;
   logic             rdy_q, rdy_d;
   logic             busy_q, busy_d;
   logic             fpend_q, fpend_d;

   assign ptr_inc = ptr_q + 2'd1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      ptr_n   = ptr_q;
      pack_d  = pack_q;
      id_d    = id_q;
      be_d    = be_q;
      cnt_d   = cnt_q;
      wr_d    = 1'b0;
      fpend_d = fpend_q;

      if (bus.START) begin
         ptr_d   = 2'd0;
         pack_d  = 32'h0;
         cnt_d   = '0;
         fpend_d = 1'b0;
         state_d = bus.DIR ? S2F_FILL : F2S_WAIT;
      end else begin
         case (state_q)
            S2F_FILL: begin
               if (bus.BYTE_STB) begin
                  case (ptr_q)
                     2'd0:    pack_d[31:24] = bus.BYTE_IN;
                     2'd1:    pack_d[23:16] = bus.BYTE_IN;
                     2'd2:    pack_d[15:8]  = bus.BYTE_IN;
                     default: pack_d[7:0]   = bus.BYTE_IN;
                  endcase
                  ptr_n = ptr_inc;
                  cnt_d = cnt_q + CNT_W'(1);
               end
               ptr_d = ptr_n;
               // A flush that lands on the completing byte rides the full write, then ends.
               if (bus.BYTE_STB && (ptr_q == 2'd3)) begin
                  state_d = S2F_WR;
                  fpend_d = bus.FLUSH;
               end else if (bus.FLUSH) begin
                  state_d = (ptr_n == 2'd0) ? IDLE : FLUSH_WR;
               end
            end

            S2F_WR: begin
               if (bus.FLUSH) fpend_d = 1'b1;
               if (!bus.FIFO_FULL) begin
                  wr_d    = 1'b1;
                  id_d    = pack_q;
                  be_d    = 4'hF;
                  pack_d  = 32'h0;
                  fpend_d = 1'b0;
                  state_d = (fpend_q || bus.FLUSH) ? IDLE : S2F_FILL;
               end
            end

            FLUSH_WR: begin
               if (!bus.FIFO_FULL) begin
                  wr_d = 1'b1;
                  id_d = pack_q;
                  case (ptr_q)
                     2'd1:    be_d = 4'b1000;
                     2'd2:    be_d = 4'b1100;
                     2'd3:    be_d = 4'b1110;
                     default: be_d = 4'b0000;
                  endcase
                  pack_d  = 32'h0;
                  ptr_d   = 2'd0;
                  state_d = IDLE;
               end
            end

            // One dead cycle after each pop lets FIFO_EMPTY reflect the new occupancy.
            F2S_WAIT: begin
               if (!bus.FIFO_EMPTY) state_d = F2S_SEND;
            end

            F2S_SEND: begin
               if (bus.BYTE_STB) begin
                  ptr_d = ptr_inc;
                  cnt_d = cnt_q + CNT_W'(1);
                  if (ptr_q == 2'd3) state_d = F2S_WAIT;
               end
            end

            default: ;
         endcase
      end

      rdy_d  = (state_d == S2F_FILL) || (state_d == F2S_SEND);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         pack_q  <= 32'h0;
         id_q    <= 32'h0;
         be_q    <= 4'h0;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
         fpend_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         pack_q  <= pack_d;
         id_q    <= id_d;
         be_q    <= be_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
         fpend_q <= fpend_d;
      end
   end

   // The pop coincides with the fourth strobe; an aborting START suppresses it.
   assign bus.FIFO_RD  = (state_q == F2S_SEND) && bus.BYTE_STB && (ptr_q == 2'd3) && !bus.START;
   assign bus.FIFO_WR  = wr_q;
   assign bus.FIFO_ID  = id_q;
   assign bus.FIFO_BE  = be_q;
   assign bus.BO1      = ptr_q[1];
   assign bus.BO0      = ptr_q[0];
   assign bus.BYTE_RDY = rdy_q;
   assign bus.BUSY     = busy_q;
   assign bus.BYTE_CNT = cnt_q;

endmodule

// File: tb/tb_scsi_byte_packer.sv
// Directed bench for scsi_byte_packer: vector table plus hand-written multi-cycle sequences.
module tb_scsi_byte_packer;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   scsi_byte_packer_if #(.CNT_W(24)) bus ();

   scsi_byte_packer #(.CNT_W(24)) dut (
      .CLK  (clk),
      ._RST (rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st, dr, sb;
      logic [7:0]  bi;
      logic        fl, fu, em;
      logic        wr;
      logic [31:0] id;
      logic [3:0]  be;
      logic        rd;
      logic [1:0]  bo;
      logic        ry, bz;
      logic [23:0] cnt;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t v(input logic st, dr, sb, input logic [7:0] bi,
                              input logic fl, fu, em, input logic wr, input logic [31:0] id,
                              input logic [3:0] be, input logic rd, input logic [1:0] bo,
                              input logic ry, bz, input logic [23:0] cnt);
      vec_t r;
      r.st = st; r.dr = dr; r.sb = sb; r.bi = bi; r.fl = fl; r.fu = fu; r.em = em;
      r.wr = wr; r.id = id; r.be = be; r.rd = rd; r.bo = bo; r.ry = ry; r.bz = bz; r.cnt = cnt;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic drv(input logic st, dr, sb, input logic [7:0] bi, input logic fl, fu, em);
      bus.START = st; bus.DIR = dr; bus.BYTE_STB = sb; bus.BYTE_IN = bi;
      bus.FLUSH = fl; bus.FIFO_FULL = fu; bus.FIFO_EMPTY = em;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      drv(0, 0, 0, 8'h00, 0, 0, 1);

      // st dr sb  bi   fl fu em | wr id            be   rd bo ry bz cnt
      tv.push_back(v(0,0,0,8'h00,0,0,1, 0,32'h0,        4'h0,0,2'd0,0,0,24'd0));
      tv.push_back(v(1,1,0,8'h00,0,0,1, 0,32'h0,        4'h0,0,2'd0,0,0,24'd0));
      tv.push_back(v(0,0,1,8'h11,0,0,1, 0,32'h0,        4'h0,0,2'd0,1,1,24'd0));
      tv.push_back(v(0,0,1,8'h22,0,0,1, 0,32'h0,        4'h0,0,2'd1,1,1,24'd1));
      tv.push_back(v(0,0,1,8'h33,0,0,1, 0,32'h0,        4'h0,0,2'd2,1,1,24'd2));
      tv.push_back(v(0,0,1,8'h44,0,0,1, 0,32'h0,        4'h0,0,2'd3,1,1,24'd3));
      tv.push_back(v(0,0,0,8'h00,0,0,1, 0,32'h0,        4'h0,0,2'd0,0,1,24'd4));
      tv.push_back(v(0,0,0,8'h00,0,0,1, 1,32'h11223344, 4'hF,0,2'd0,1,1,24'd4));
      tv.push_back(v(0,0,0,8'h00,0,0,1, 0,32'h0,        4'h0,0,2'd0,1,1,24'd4));
      tv.push_back(v(1,1,0,8'h00,0,0,1, 0,32'h0,        4'h0,0,2'd0,1,1,24'd4));
      tv.push_back(v(0,0,1,8'hA1,0,0,1, 0,32'h0,        4'h0,0,2'd0,1,1,24'd0));
      tv.push_back(v(0,0,1,8'hA2,0,0,1, 0,32'h0,        4'h0,0,2'd1,1,1,24'd1));
      tv.push_back(v(0,0,1,8'hA3,0,0,1, 0,32'h0,        4'h0,0,2'd2,1,1,24'd2));
      tv.push_back(v(0,0,1,8'hA4,0,0,1, 0,32'h0,        4'h0,0,2'd3,1,1,24'd3));
      tv.push_back(v(0,0,0,8'h00,0,0,1, 0,32'h0,        4'h0,0,2'd0,0,1,24'd4));
      tv.push_back(v(0,0,1,8'hA5,0,0,1, 1,32'hA1A2A3A4, 4'hF,0,2'd0,1,1,24'd4));
      tv.push_back(v(0,0,1,8'hA6,0,0,1, 0,32'h0,        4'h0,0,2'd1,1,1,24'd5));
      tv.push_back(v(0,0,0,8'h00,1,0,1, 0,32'h0,        4'h0,0,2'd2,1,1,24'd6));
      tv.push_back(v(0,0,0,8'h00,0,0,1, 0,32'h0,        4'h0,0,2'd2,0,1,24'd6));
      tv.push_back(v(0,0,0,8'h00,0,0,1, 1,32'hA5A60000, 4'hC,0,2'd0,0,0,24'd6));
      tv.push_back(v(0,0,0,8'h00,0,0,1, 0,32'h0,        4'h0,0,2'd0,0,0,24'd6));
      tv.push_back(v(1,0,0,8'h00,0,0,0, 0,32'h0,        4'h0,0,2'd0,0,0,24'd6));
      tv.push_back(v(0,0,0,8'h00,0,0,0, 0,32'h0,        4'h0,0,2'd0,0,1,24'd0));
      tv.push_back(v(0,0,1,8'h00,0,0,0, 0,32'h0,        4'h0,0,2'd0,1,1,24'd0));
      tv.push_back(v(0,0,1,8'h00,0,0,0, 0,32'h0,        4'h0,0,2'd1,1,1,24'd1));
      tv.push_back(v(0,0,1,8'h00,0,0,0, 0,32'h0,        4'h0,0,2'd2,1,1,24'd2));
      tv.push_back(v(0,0,1,8'h00,0,0,0, 0,32'h0,        4'h0,1,2'd3,1,1,24'd3));
      tv.push_back(v(0,0,0,8'h00,0,0,0, 0,32'h0,        4'h0,0,2'd0,0,1,24'd4));
      tv.push_back(v(0,0,1,8'h00,0,0,0, 0,32'h0,        4'h0,0,2'd0,1,1,24'd4));
      tv.push_back(v(0,0,1,8'h00,0,0,0, 0,32'h0,        4'h0,0,2'd1,1,1,24'd5));
      tv.push_back(v(0,0,1,8'h00,0,0,0, 0,32'h0,        4'h0,0,2'd2,1,1,24'd6));
      tv.push_back(v(0,0,1,8'h00,0,0,0, 0,32'h0,        4'h0,1,2'd3,1,1,24'd7));
      tv.push_back(v(0,0,0,8'h00,0,0,1, 0,32'h0,        4'h0,0,2'd0,0,1,24'd8));
      tv.push_back(v(0,0,1,8'h00,0,0,1, 0,32'h0,        4'h0,0,2'd0,0,1,24'd8));
      tv.push_back(v(0,0,0,8'h00,0,0,0, 0,32'h0,        4'h0,0,2'd0,0,1,24'd8));
      tv.push_back(v(0,0,0,8'h00,0,0,0, 0,32'h0,        4'h0,0,2'd0,1,1,24'd8));
      tv.push_back(v(0,0,1,8'h00,0,0,0, 0,32'h0,        4'h0,0,2'd0,1,1,24'd8));
      tv.push_back(v(0,0,1,8'h00,0,0,0, 0,32'h0,        4'h0,0,2'd1,1,1,24'd9));
      tv.push_back(v(0,0,1,8'h00,0,0,0, 0,32'h0,        4'h0,0,2'd2,1,1,24'd10));
      tv.push_back(v(1,0,1,8'h00,0,0,0, 0,32'h0,        4'h0,0,2'd3,1,1,24'd11));
      tv.push_back(v(0,0,0,8'h00,0,0,0, 0,32'h0,        4'h0,0,2'd0,0,1,24'd0));
      tv.push_back(v(0,0,0,8'h00,1,0,0, 0,32'h0,        4'h0,0,2'd0,1,1,24'd0));
      tv.push_back(v(0,0,0,8'h00,0,0,0, 0,32'h0,        4'h0,0,2'd0,1,1,24'd0));

      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tv[k]) begin
         drv(tv[k].st, tv[k].dr, tv[k].sb, tv[k].bi, tv[k].fl, tv[k].fu, tv[k].em);
         #1;
         chk($sformatf("v%0d.wr", k),   bus.FIFO_WR,  tv[k].wr);
         if (tv[k].wr) begin
            chk($sformatf("v%0d.id", k), bus.FIFO_ID, tv[k].id);
            chk($sformatf("v%0d.be", k), bus.FIFO_BE, tv[k].be);
         end
         chk($sformatf("v%0d.rd", k),   bus.FIFO_RD,  tv[k].rd);
         chk($sformatf("v%0d.bo", k),   {bus.BO1, bus.BO0}, tv[k].bo);
         chk($sformatf("v%0d.rdy", k),  bus.BYTE_RDY, tv[k].ry);
         chk($sformatf("v%0d.busy", k), bus.BUSY,     tv[k].bz);
         chk($sformatf("v%0d.cnt", k),  bus.BYTE_CNT, tv[k].cnt);
         tick();
      end

      // Backpressure: FIFO_FULL held for 5 cycles after the 4th byte, extra strobes dropped
      drv(1, 1, 0, 8'h00, 0, 0, 1); tick();
      for (int i = 0; i < 4; i++) begin
         drv(0, 0, 1, 8'(8'hB0 + i), 0, 0, 1); tick();
      end
      for (int i = 0; i < 5; i++) begin
         drv(0, 0, 1, 8'hFF, 0, 1, 1); #1;
         chk("bp.rdy", bus.BYTE_RDY, 0);
         chk("bp.wr", bus.FIFO_WR, 0);
         tick();
      end
      drv(0, 0, 0, 8'h00, 0, 0, 1); #1;
      chk("bp.wr_wait", bus.FIFO_WR, 0);
      tick(); #1;
      chk("bp.wr", bus.FIFO_WR, 1);
      chk("bp.id", bus.FIFO_ID, 32'hB0B1B2B3);
      chk("bp.be", bus.FIFO_BE, 4'hF);
      chk("bp.cnt", bus.BYTE_CNT, 4);
      tick(); #1;
      chk("bp.wr_once", bus.FIFO_WR, 0);
      chk("bp.busy", bus.BUSY, 1);
      drv(0, 0, 0, 8'h00, 1, 0, 1); tick(); #1;
      chk("fl0.busy", bus.BUSY, 0);
      chk("fl0.wr", bus.FIFO_WR, 0);

      // FLUSH together with the completing byte: one full write only
      drv(0, 0, 0, 8'h00, 0, 0, 1); tick();
      drv(1, 1, 0, 8'h00, 0, 0, 1); tick();
      drv(0, 0, 1, 8'hC1, 0, 0, 1); tick();
      drv(0, 0, 1, 8'hC2, 0, 0, 1); tick();
      drv(0, 0, 1, 8'hC3, 0, 0, 1); tick();
      drv(0, 0, 1, 8'hC4, 1, 0, 1); tick();
      drv(0, 0, 0, 8'h00, 0, 0, 1); #1;
      chk("fs.rdy", bus.BYTE_RDY, 0);
      chk("fs.busy", bus.BUSY, 1);
      tick(); #1;
      chk("fs.wr", bus.FIFO_WR, 1);
      chk("fs.id", bus.FIFO_ID, 32'hC1C2C3C4);
      chk("fs.be", bus.FIFO_BE, 4'hF);
      chk("fs.busy_end", bus.BUSY, 0);
      chk("fs.cnt", bus.BYTE_CNT, 4);
      tick(); #1;
      chk("fs.no_extra", bus.FIFO_WR, 0);

      // One-byte flush held off by FIFO_FULL
      drv(1, 1, 0, 8'h00, 0, 0, 1); tick();
      drv(0, 0, 1, 8'hD1, 0, 0, 1); tick();
      drv(0, 0, 0, 8'h00, 1, 0, 1); tick();
      drv(0, 0, 0, 8'h00, 0, 1, 1); #1;
      chk("f1.busy", bus.BUSY, 1);
      chk("f1.rdy", bus.BYTE_RDY, 0);
      tick(); #1;
      chk("f1.hold", bus.FIFO_WR, 0);
      drv(0, 0, 0, 8'h00, 0, 0, 1); tick(); #1;
      chk("f1.wr", bus.FIFO_WR, 1);
      chk("f1.id", bus.FIFO_ID, 32'hD1000000);
      chk("f1.be", bus.FIFO_BE, 4'b1000);
      chk("f1.busy_end", bus.BUSY, 0);
      tick();

      // Three-byte flush
      drv(1, 1, 0, 8'h00, 0, 0, 1); tick();
      drv(0, 0, 1, 8'hE1, 0, 0, 1); tick();
      drv(0, 0, 1, 8'hE2, 0, 0, 1); tick();
      drv(0, 0, 1, 8'hE3, 0, 0, 1); tick();
      drv(0, 0, 0, 8'h00, 1, 0, 1); tick();
      drv(0, 0, 0, 8'h00, 0, 0, 1); tick(); #1;
      chk("f3.wr", bus.FIFO_WR, 1);
      chk("f3.id", bus.FIFO_ID, 32'hE1E2E3_00);
      chk("f3.be", bus.FIFO_BE, 4'b1110);
      chk("f3.cnt", bus.BYTE_CNT, 3);
      tick();

      // Asynchronous reset after two S2F bytes
      drv(1, 1, 0, 8'h00, 0, 0, 1); tick();
      drv(0, 0, 1, 8'hF1, 0, 0, 1); tick();
      drv(0, 0, 1, 8'hF2, 0, 0, 1); tick();
      drv(0, 0, 0, 8'h00, 0, 0, 1); #1;
      chk("ar.pre_cnt", bus.BYTE_CNT, 2);
      chk("ar.pre_bo", {bus.BO1, bus.BO0}, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("ar.busy", bus.BUSY, 0);
      chk("ar.rdy", bus.BYTE_RDY, 0);
      chk("ar.bo", {bus.BO1, bus.BO0}, 0);
      chk("ar.cnt", bus.BYTE_CNT, 0);
      chk("ar.wr", bus.FIFO_WR, 0);
      chk("ar.rd", bus.FIFO_RD, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(); #1;
      chk("ar.idle", bus.BUSY, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/scsi_byte_packer.md
Name: scsi_byte_packer

Overview:
- Byte-lane sequencer between the 32-bit FIFO and the 8-bit SCSI datapath stage.
- SCSI→FIFO (S2F): packs successive SCSI bytes into big-endian longwords and issues FIFO writes.
- FIFO→SCSI (F2S): steps the byte offset BO1/BO0 across a FIFO longword and pops the FIFO after the fourth byte.
- Also keeps a running byte count and handles partial-longword flush at end of transfer.

Parameters:
- CNT_W, 24, width of the transferred-byte counter.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- _RST  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse: clear pointer, pack register and counter; latch DIR.
- DIR  in  1  direction sampled at START: 1 = S2F, 0 = F2S.
- BYTE_STB  in  1  one-cycle strobe: a SCSI byte was transferred this cycle.
- BYTE_IN  in  8  SCSI receive byte, valid with BYTE_STB in S2F.
- FLUSH  in  1  one-cycle pulse: end of S2F transfer; write any partial longword.
- FIFO_FULL  in  1  FIFO cannot accept a write.
- FIFO_EMPTY  in  1  FIFO has no longword to read.
- FIFO_WR  out  1  one-cycle FIFO write strobe.
- FIFO_ID  out  32  packed longword to FIFO.
- FIFO_BE  out  4  byte enables for FIFO_ID; bit3 = [31:24].
- FIFO_RD  out  1  one-cycle FIFO pop strobe.
- BO1  out  1  byte offset, high bit.
- BO0  out  1  byte offset, low bit.
- BYTE_RDY  out  1  block can take/supply a byte this cycle.
- BUSY  out  1  transfer active (not IDLE).
- BYTE_CNT  out  CNT_W  bytes transferred since START.

Behaviour:
- Reset: all outputs 0; state IDLE; pointer {BO1,BO0} = 0; pack register 0.
- Lane mapping: offset 0 = bits [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0] (68k big-endian). {BO1,BO0} always equals the current pointer.
- States: IDLE, S2F_FILL, S2F_WR, F2S_WAIT, F2S_SEND, FLUSH_WR.
- IDLE:
  - START → S2F_FILL if DIR=1, else F2S_WAIT.
  - Pointer, pack register and BYTE_CNT cleared.
  - BYTE_STB ignored.
- START in any state: aborts immediately with the same clearing; no FIFO_WR/FIFO_RD is issued that cycle.
- S2F_FILL:
  - BYTE_RDY=1.
  - On BYTE_STB: write BYTE_IN to lane[pointer]; pointer+1 (mod 4); BYTE_CNT+1.
  - If pointer was 3 → S2F_WR.
- S2F_WR:
  - BYTE_RDY=0.
  - FIFO_WR=1 with FIFO_BE=4'hF in the first cycle FIFO_FULL=0; that is a registered pulse, exactly 1 cycle.
  - Next cycle: pack register cleared, → S2F_FILL.
  - BYTE_STB while BYTE_RDY=0 is a protocol error: byte dropped, counter unchanged.
- FLUSH (S2F only, from S2F_FILL):
  - Pointer=0: no write; → IDLE.
  - Pointer=n (1..3): → FLUSH_WR. Issue FIFO_WR when FIFO_FULL=0 with the top n BE bits set (n=1→1000, 2→1100, 3→1110); unused lanes 0. Then → IDLE.
  - FLUSH and BYTE_STB in the same cycle: the byte is packed first, then the flush uses the updated pointer. If that completes a longword, a full write (BE=F) occurs and no extra write follows.
- F2S_WAIT: BYTE_RDY=0; when FIFO_EMPTY=0 → F2S_SEND.
- F2S_SEND:
  - BYTE_RDY=1.
  - On BYTE_STB: pointer+1; BYTE_CNT+1.
  - If pointer was 3: FIFO_RD=1 for that cycle (combined with the strobe, single pulse); pointer → 0; → F2S_WAIT.
  - The 1-cycle wait gives FIFO_EMPTY time to update.
- FLUSH in F2S is ignored.
- BYTE_CNT wraps modulo 2^CNT_W without a flag.
- BUSY=1 in every state except IDLE.
- Async reset mid-transfer: everything cleared immediately, no strobe glitch; partial data is lost.

Test Plan:
- S2F full longword: START DIR=1; 4 strobes with bytes 11,22,33,44; FIFO_FULL=0 → single FIFO_WR pulse, FIFO_ID=32'h11223344, BE=F, BYTE_CNT=4, BO back to 0.
- S2F backpressure: FIFO_FULL=1 for 5 cycles after the 4th byte → BYTE_RDY=0 throughout; extra BYTE_STB dropped; FIFO_WR occurs 1 cycle after FIFO_FULL falls, exactly once.
- S2F flush: 6 bytes A1..A6 then FLUSH → writes 32'hA1A2A3A4 BE=F, then 32'hA5A60000 BE=C; → IDLE; BYTE_CNT=6.
- F2S: START DIR=0, FIFO_EMPTY=0, 8 strobes → BO sequence 00,01,10,11,00,01,10,11; FIFO_RD pulses on the 4th and 8th strobes only; BYTE_RDY low 1 cycle between longwords.
- F2S empty stall: FIFO_EMPTY=1 → BYTE_RDY=0, no FIFO_RD; on deassert, BYTE_RDY=1 the next cycle.
- Abort/reset: _RST low after 2 S2F bytes → all outputs 0 asynchronously; START mid-F2S at BO=2 → BO=0, BYTE_CNT=0, no FIFO_RD.
